// File: rtl/exc_pkg.sv
// Shared encodings for the commit-end exception controller: MIPS ExcCode
// values, c_exc flag positions and the controller FSM states.
package exc_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0,
                           EXC_MOD  = 5'd1,
                           EXC_TLBL = 5'd2,
                           EXC_TLBS = 5'd3,
                           EXC_ADEL = 5'd4,
                           EXC_ADES = 5'd5,
                           EXC_SYS  = 5'd8,
                           EXC_BP   = 5'd9,
                           EXC_RI   = 5'd10,
                           EXC_OV   = 5'd12;

    localparam int EXC_W = 11;

    // Flag positions inside c_exc; lower index means higher priority.
    localparam int B_IF_ADEL  = 0,
                   B_IF_TLBL  = 1,
                   B_RI       = 2,
                   B_OV       = 3,
                   B_SYS      = 4,
                   B_BP       = 5,
                   B_MEM_ADEL = 6,
                   B_MEM_ADES = 7,
                   B_MEM_TLBL = 8,
                   B_MEM_TLBS = 9,
                   B_MEM_MOD  = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    // Which address feeds BadVAddr/EntryHi for the winning cause.
    typedef enum logic {
        SRC_PC   = 1'b0,
        SRC_DATA = 1'b1
    } addr_src_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Picks the single winning exception cause by MIPS priority and reports its
// ExcCode plus which CP0 address registers it updates and from where.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic             i_int,
    input  logic [EXC_W-1:0] i_exc,
    output logic             o_hit,
    output logic [4:0]       o_exccode,
    output logic             o_badvaddr_ena,
    output logic             o_entryhi_ena,
    output addr_src_t        o_addr_src,
    output logic             o_tlb_miss
);

    always_comb begin
        // NOTE: every output gets a default before the priority chain so no
        // path through the if/else leaves a value held, which would infer a latch.
        o_hit          = 1'b1;
        o_exccode      = EXC_INT;
        o_badvaddr_ena = 1'b0;
        o_entryhi_ena  = 1'b0;
        o_addr_src     = SRC_PC;
        o_tlb_miss     = 1'b0;

        if (i_int) begin
            o_exccode = EXC_INT;
        end else if (i_exc[B_IF_ADEL]) begin
            o_exccode      = EXC_ADEL;
            o_badvaddr_ena = 1'b1;
        end else if (i_exc[B_IF_TLBL]) begin
            o_exccode      = EXC_TLBL;
            o_badvaddr_ena = 1'b1;
            o_entryhi_ena  = 1'b1;
            o_tlb_miss     = 1'b1;
        end else if (i_exc[B_RI]) begin
            o_exccode = EXC_RI;
        end else if (i_exc[B_OV]) begin
            o_exccode = EXC_OV;
        end else if (i_exc[B_SYS]) begin
            o_exccode = EXC_SYS;
        end else if (i_exc[B_BP]) begin
            o_exccode = EXC_BP;
        end else if (i_exc[B_MEM_ADEL]) begin
            o_exccode      = EXC_ADEL;
            o_badvaddr_ena = 1'b1;
            o_addr_src     = SRC_DATA;
        end else if (i_exc[B_MEM_ADES]) begin
            o_exccode      = EXC_ADES;
            o_badvaddr_ena = 1'b1;
            o_addr_src     = SRC_DATA;
        end else if (i_exc[B_MEM_TLBL]) begin
            o_exccode      = EXC_TLBL;
            o_badvaddr_ena = 1'b1;
            o_entryhi_ena  = 1'b1;
            o_addr_src     = SRC_DATA;
            o_tlb_miss     = 1'b1;
        end else if (i_exc[B_MEM_TLBS]) begin
            o_exccode      = EXC_TLBS;
            o_badvaddr_ena = 1'b1;
            o_entryhi_ena  = 1'b1;
            o_addr_src     = SRC_DATA;
            o_tlb_miss     = 1'b1;
        end else if (i_exc[B_MEM_MOD]) begin
            o_exccode      = EXC_MOD;
            o_badvaddr_ena = 1'b1;
            o_entryhi_ena  = 1'b1;
            o_addr_src     = SRC_DATA;
        end else begin
            o_hit = 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Precise-exception controller: registers the CP0 update for the winning
// cause (or ERET), flushes the pipeline, then redirects fetch.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int          FLUSH_CYCLES  = 2,
    parameter logic [31:0] GEN_VECTOR    = 32'hBFC00380,
    parameter logic [31:0] REFILL_VECTOR = 32'hBFC00200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c_valid,
    output logic             c_ready,
    input  logic [31:0]      c_pc,
    input  logic             c_bd,
    input  logic [EXC_W-1:0] c_exc,
    input  logic             c_tlb_refill,
    input  logic [31:0]      c_data_vaddr,
    input  logic             c_eret,
    input  logic             cp0_has_int,
    input  logic             cp0_status_exl,
    input  logic             cp0_cause_bd,
    input  logic [31:0]      cp0_epc,
    output logic             w_cp0_update_ena,
    output logic [4:0]       w_cp0_exccode,
    output logic             w_cp0_bd,
    output logic             w_cp0_exl,
    output logic [31:0]      w_cp0_epc,
    output logic             w_cp0_badvaddr_ena,
    output logic [31:0]      w_cp0_badvaddr,
    output logic             w_cp0_entryhi_ena,
    output logic [31:0]      w_cp0_entryhi,
    output logic             cp0_cls_exl,
    output logic             flush,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    input  logic             redir_ready
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t          r_state, w_next;
    logic [CNT_W-1:0] r_cnt;

    logic        r_update_ena, r_cls_exl, r_bd, r_badvaddr_ena, r_entryhi_ena;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc, r_addr, r_redir_pc;

    logic        w_hit, w_bva_ena, w_ehi_ena, w_tlb_miss;
    logic [4:0]  w_exccode;
    addr_src_t   w_src;

    exc_prio_enc u_prio (
        .i_int          (cp0_has_int),
        .i_exc          (c_exc),
        .o_hit          (w_hit),
        .o_exccode      (w_exccode),
        .o_badvaddr_ena (w_bva_ena),
        .o_entryhi_ena  (w_ehi_ena),
        .o_addr_src     (w_src),
        .o_tlb_miss     (w_tlb_miss)
    );

    logic        w_take;
    logic [31:0] w_addr, w_epc, w_target;
    logic        w_bd, w_refill;

    assign w_take   = c_valid && (r_state == ST_IDLE) && (w_hit || c_eret);
    assign w_addr   = (w_src == SRC_DATA) ? c_data_vaddr : c_pc;
    // A nested exception (EXL already set) must not disturb EPC/BD.
    assign w_epc    = cp0_status_exl ? cp0_epc : (c_bd ? c_pc - 32'd4 : c_pc);
    assign w_bd     = cp0_status_exl ? cp0_cause_bd : c_bd;
    assign w_refill = w_tlb_miss && c_tlb_refill && !cp0_status_exl;
    assign w_target = w_hit ? (w_refill ? REFILL_VECTOR : GEN_VECTOR) : cp0_epc;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_take)          w_next = ST_FLUSH;
            ST_FLUSH: if (r_cnt == '0)     w_next = ST_REDIR;
            ST_REDIR: if (redir_ready)     w_next = ST_IDLE;
            default:                       w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_update_ena   <= 1'b0;
            r_cls_exl      <= 1'b0;
            r_exccode      <= '0;
            r_bd           <= 1'b0;
            r_epc          <= '0;
            r_badvaddr_ena <= 1'b0;
            r_entryhi_ena  <= 1'b0;
            r_addr         <= '0;
            r_redir_pc     <= '0;
        end else begin
            r_update_ena <= w_take && w_hit;
            r_cls_exl    <= w_take && !w_hit;
            if (w_take) begin
                r_cnt          <= CNT_W'(FLUSH_CYCLES - 1);
                r_exccode      <= w_exccode;
                r_bd           <= w_bd;
                r_epc          <= w_epc;
                r_badvaddr_ena <= w_hit && w_bva_ena;
                r_entryhi_ena  <= w_hit && w_ehi_ena;
                r_addr         <= w_addr;
                r_redir_pc     <= w_target;
            end else begin
                r_badvaddr_ena <= 1'b0;
                r_entryhi_ena  <= 1'b0;
                if (r_state == ST_FLUSH) r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign c_ready            = (r_state == ST_IDLE);
    assign flush              = (r_state == ST_FLUSH);
    assign redir_valid        = (r_state == ST_REDIR);
    assign redir_pc           = r_redir_pc;
    assign w_cp0_update_ena   = r_update_ena;
    assign w_cp0_exccode      = r_exccode;
    assign w_cp0_bd           = r_bd;
    assign w_cp0_exl          = r_update_ena;
    assign w_cp0_epc          = r_epc;
    assign w_cp0_badvaddr_ena = r_badvaddr_ena;
    assign w_cp0_badvaddr     = r_addr;
    assign w_cp0_entryhi_ena  = r_entryhi_ena;
    assign w_cp0_entryhi      = r_addr;
    assign cp0_cls_exl        = r_cls_exl;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: a driver issues directed and random commits,
// a reference model queues expected CP0 updates and redirects, monitors compare.
module tb_exc_ctrl;

    localparam int          FC    = 2;
    localparam logic [31:0] GEN_V = 32'hBFC00380;
    localparam logic [31:0] REF_V = 32'hBFC00200;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_valid, c_ready, c_bd, c_tlb_refill, c_eret;
    logic [31:0] c_pc, c_data_vaddr;
    logic [10:0] c_exc;
    logic        cp0_has_int, cp0_status_exl, cp0_cause_bd;
    logic [31:0] cp0_epc;
    logic        upd, bd_o, exl_o, bva_ena, ehi_ena, cls_exl, flush, redir_valid, redir_ready;
    logic [4:0]  exccode;
    logic [31:0] epc_o, bva, ehi, redir_pc;

    always #5 clk = ~clk;

    exc_ctrl #(.FLUSH_CYCLES(FC), .GEN_VECTOR(GEN_V), .REFILL_VECTOR(REF_V)) dut (
        .clk(clk), .rst(rst),
        .c_valid(c_valid), .c_ready(c_ready), .c_pc(c_pc), .c_bd(c_bd),
        .c_exc(c_exc), .c_tlb_refill(c_tlb_refill), .c_data_vaddr(c_data_vaddr),
        .c_eret(c_eret), .cp0_has_int(cp0_has_int), .cp0_status_exl(cp0_status_exl),
        .cp0_cause_bd(cp0_cause_bd), .cp0_epc(cp0_epc),
        .w_cp0_update_ena(upd), .w_cp0_exccode(exccode), .w_cp0_bd(bd_o),
        .w_cp0_exl(exl_o), .w_cp0_epc(epc_o), .w_cp0_badvaddr_ena(bva_ena),
        .w_cp0_badvaddr(bva), .w_cp0_entryhi_ena(ehi_ena), .w_cp0_entryhi(ehi),
        .cp0_cls_exl(cls_exl), .flush(flush), .redir_valid(redir_valid),
        .redir_pc(redir_pc), .redir_ready(redir_ready)
    );

    typedef struct {
        logic [31:0] pc;
        logic        bd;
        logic [10:0] exc;
        logic        refill;
        logic [31:0] vaddr;
        logic        eret;
        logic        has_int;
        logic        exl;
        logic        cause_bd;
        logic [31:0] epc;
    } stim_t;

    typedef struct {
        logic        upd;
        logic        cls;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] epc;
        logic        bva_ena;
        logic [31:0] bva;
        logic        ehi_ena;
        logic [31:0] ehi;
    } cp0_exp_t;

    cp0_exp_t    q_cp0[$];
    logic [31:0] q_redir[$];
    cp0_exp_t    mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;

    // ExcCode for each c_exc bit, listed in priority order.
    localparam int CODE_OF[11] = '{4, 2, 10, 12, 8, 9, 4, 5, 2, 3, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Returns 1 when the commit should trigger an exception or ERET.
    function automatic logic model(input stim_t s, output cp0_exp_t e, output logic [31:0] tgt);
        int win;
        win = -1;
        for (int i = 10; i >= 0; i--) if (s.exc[i]) win = i;
        if (s.has_int) win = 11;
        e   = '{default: '0};
        tgt = '0;
        if (win < 0 && !s.eret) return 1'b0;
        if (win < 0) begin
            e.cls = 1'b1;
            tgt   = s.epc;
            return 1'b1;
        end
        e.upd     = 1'b1;
        e.code    = (win == 11) ? 5'd0 : 5'(CODE_OF[win]);
        e.bd      = s.exl ? s.cause_bd : s.bd;
        e.epc     = s.exl ? s.epc : (s.bd ? s.pc - 32'd4 : s.pc);
        e.bva_ena = (win <= 1) || (win >= 6 && win <= 10);
        e.bva     = (win <= 1) ? s.pc : s.vaddr;
        e.ehi_ena = (win == 1) || (win >= 8 && win <= 10);
        e.ehi     = e.bva;
        tgt = ((e.code == 5'd2 || e.code == 5'd3) && s.refill && !s.exl) ? REF_V : GEN_V;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (upd === 1'b1 || cls_exl === 1'b1) begin
            if (q_cp0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL cp0_strobe: unexpected strobe upd=%0b cls=%0b at %0t", upd, cls_exl, $time);
            end else begin
                mon_e = q_cp0.pop_front();
                check1("update_ena", upd, mon_e.upd);
                check1("cls_exl", cls_exl, mon_e.cls);
                if (mon_e.upd) begin
                    check("exccode", 32'(exccode), 32'(mon_e.code));
                    check1("cp0_bd", bd_o, mon_e.bd);
                    check1("cp0_exl", exl_o, 1'b1);
                    check("cp0_epc", epc_o, mon_e.epc);
                    check1("badvaddr_ena", bva_ena, mon_e.bva_ena);
                    if (mon_e.bva_ena) check("badvaddr", bva, mon_e.bva);
                    check1("entryhi_ena", ehi_ena, mon_e.ehi_ena);
                    if (mon_e.ehi_ena) check("entryhi", ehi, mon_e.ehi);
                end else begin
                    check1("eret_badvaddr_ena", bva_ena, 1'b0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (redir_valid === 1'b1) begin
            if (q_redir.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL redir_unexpected: redir_pc=0x%08h at %0t", redir_pc, $time);
            end else begin
                check("redir_pc", redir_pc, q_redir[0]);
                check1("c_ready_in_redir", c_ready, 1'b0);
                if (redir_ready) void'(q_redir.pop_front());
            end
        end
    end

    task automatic drive(input stim_t s);
        c_pc = s.pc; c_bd = s.bd; c_exc = s.exc; c_tlb_refill = s.refill;
        c_data_vaddr = s.vaddr; c_eret = s.eret; cp0_has_int = s.has_int;
        cp0_status_exl = s.exl; cp0_cause_bd = s.cause_bd; cp0_epc = s.epc;
    endtask

    // hold < 0 picks a random number of redir_ready=0 cycles.
    task automatic issue(input stim_t s, input int hold);
        cp0_exp_t    e;
        logic [31:0] tgt;
        logic        act;
        int          k;
        act = model(s, e, tgt);
        @(posedge clk); #1;
        drive(s);
        c_valid = 1'b1;
        if (act) begin
            q_cp0.push_back(e);
            q_redir.push_back(tgt);
        end
        @(posedge clk); #1;
        if (!act) begin
            c_valid = 1'b0;
            @(negedge clk);
            check1("noact_ready", c_ready, 1'b1);
            check1("noact_flush", flush, 1'b0);
            return;
        end
        // Garbage commits while busy must be ignored.
        c_exc = 11'($urandom); c_eret = 1'b1; cp0_epc = $urandom; cp0_has_int = 1'b1;
        for (int i = 0; i < FC; i++) begin
            @(negedge clk);
            check1("flush_on", flush, 1'b1);
            check1("c_ready_busy", c_ready, 1'b0);
            check1("redir_early", redir_valid, 1'b0);
        end
        @(negedge clk);
        check1("flush_off", flush, 1'b0);
        check1("redir_on", redir_valid, 1'b1);
        k = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
        repeat (k) @(negedge clk);
        @(posedge clk); #1;
        redir_ready = 1'b1;
        c_valid     = 1'b0;
        @(posedge clk); #1;
        redir_ready = 1'b0;
        @(negedge clk);
        check1("ready_after", c_ready, 1'b1);
        check1("redir_after", redir_valid, 1'b0);
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        int    r;
        s.pc       = $urandom & 32'hFFFF_FFFC;
        s.bd       = 1'($urandom_range(0, 1));
        s.refill   = 1'($urandom_range(0, 1));
        s.vaddr    = $urandom;
        s.exl      = 1'($urandom_range(0, 1));
        s.cause_bd = 1'($urandom_range(0, 1));
        s.epc      = $urandom;
        s.has_int  = ($urandom_range(0, 9) == 0);
        s.eret     = ($urandom_range(0, 4) == 0);
        r = $urandom_range(0, 9);
        if (r < 4) s.exc = '0;
        else begin
            s.exc = 11'(1 << $urandom_range(0, 10));
            if (r >= 7) s.exc[$urandom_range(0, 10)] = 1'b1;
        end
        return s;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t       s;
        cp0_exp_t    e;
        logic [31:0] tgt;
        s = '{default: '0};
        rst = 1'b1; c_valid = 1'b0; redir_ready = 1'b0;
        drive(s);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("rst_c_ready", c_ready, 1'b1);
        check1("rst_flush", flush, 1'b0);
        check1("rst_redir_valid", redir_valid, 1'b0);
        check("rst_redir_pc", redir_pc, 32'd0);
        check1("rst_update", upd, 1'b0);
        check1("rst_cls", cls_exl, 1'b0);
        check("rst_epc", epc_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Ov, not in a delay slot
        s = '{default: '0}; s.pc = 32'h8000_1000; s.exc[3] = 1'b1;
        issue(s, -1);
        // if_adel beats mem_ades; delay slot moves EPC back one word
        s = '{default: '0}; s.pc = 32'h8000_0004; s.bd = 1'b1; s.exc[0] = 1'b1; s.exc[7] = 1'b1;
        issue(s, -1);
        // mem_tlbs refill, then the same with EXL already set
        s = '{default: '0}; s.exc[9] = 1'b1; s.refill = 1'b1; s.vaddr = 32'h0040_2ABC;
        issue(s, -1);
        s.exl = 1'b1; s.cause_bd = 1'b1; s.epc = 32'h1234_5678;
        issue(s, -1);
        // ERET with fetch stalling three cycles
        s = '{default: '0}; s.eret = 1'b1; s.epc = 32'h8000_2000;
        issue(s, 3);
        // Exception wins over ERET on the same instruction
        s = '{default: '0}; s.eret = 1'b1; s.exc[5] = 1'b1; s.pc = 32'h8000_0100; s.epc = 32'h8000_2000;
        issue(s, 0);
        // Delay-slot EPC at address 0 wraps
        s = '{default: '0}; s.pc = 32'h0; s.bd = 1'b1; s.exc[2] = 1'b1;
        issue(s, 1);
        // Plain commit: no action
        s = '{default: '0}; s.pc = 32'h8000_0200;
        issue(s, 0);

        for (int n = 0; n < 80; n++) issue(rand_stim(), -1);

        // Interrupt beats sys; reset lands during the flush
        s = '{default: '0}; s.has_int = 1'b1; s.exc[4] = 1'b1; s.pc = 32'h8000_0300;
        void'(model(s, e, tgt));
        q_cp0.push_back(e);
        @(posedge clk); #1;
        drive(s);
        c_valid = 1'b1;
        @(posedge clk); #1;
        c_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check1("pre_rst_flush", flush, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check1("midrst_c_ready", c_ready, 1'b1);
        check1("midrst_flush", flush, 1'b0);
        check1("midrst_redir_valid", redir_valid, 1'b0);
        check("midrst_redir_pc", redir_pc, 32'd0);
        check1("midrst_update", upd, 1'b0);
        repeat (3) @(negedge clk);
        check1("midrst_stays_idle", c_ready, 1'b1);

        issue(rand_stim(), -1);
        s = '{default: '0}; s.exc[10] = 1'b1; s.vaddr = 32'hDEAD_B000; s.refill = 1'b1;
        issue(s, -1);

        repeat (2) @(negedge clk);
        check("cp0_queue_empty", 32'(q_cp0.size()), 32'd0);
        check("redir_queue_empty", 32'(q_redir.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Precise-exception controller at the commit end of the MIPS pipeline. It samples each committing instruction's exception flags, ERET and the pending-interrupt indication, and picks one winner by MIPS priority. It drives the CP0 exception-update and clear-EXL strobes and the pipeline flush. It then hands the handler vector or EPC to fetch over a valid/ready redirect handshake.

## Interface
- FLUSH_CYCLES, 2: cycles flush is held; must be at least 1.
- GEN_VECTOR, 32'hBFC00380: general exception vector (BEV=1).
- REFILL_VECTOR, 32'hBFC00200: TLB refill vector (BEV=1).
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- c_valid  in  1  commit-stage instruction present
- c_ready  out  1  controller accepts a commit (state IDLE)
- c_pc  in  32  instruction PC
- c_bd  in  1  instruction is in a branch delay slot
- c_exc  in  11  flags: [0] if_adel, [1] if_tlbl, [2] ri, [3] ov, [4] sys, [5] bp, [6] mem_adel, [7] mem_ades, [8] mem_tlbl, [9] mem_tlbs, [10] mem_mod
- c_tlb_refill  in  1  TLB flag is a refill miss, not an invalid entry
- c_data_vaddr  in  32  data virtual address
- c_eret  in  1  instruction is ERET
- cp0_has_int  in  1  unmasked interrupt pending
- cp0_status_exl  in  1  current Status.EXL
- cp0_cause_bd  in  1  current Cause.BD
- cp0_epc  in  32  current EPC
- w_cp0_update_ena  out  1  one-cycle exception-update strobe
- w_cp0_exccode  out  5  ExcCode
- w_cp0_bd  out  1  BD value to write
- w_cp0_exl  out  1  always 1 with an update
- w_cp0_epc  out  32  EPC value to write
- w_cp0_badvaddr_ena  out  1  BadVAddr write enable
- w_cp0_badvaddr  out  32  BadVAddr value
- w_cp0_entryhi_ena  out  1  EntryHi VPN2 write enable
- w_cp0_entryhi  out  32  faulting address (VPN2 in [31:13])
- cp0_cls_exl  out  1  one-cycle clear-EXL strobe for ERET
- flush  out  1  kill all younger pipeline stages
- redir_valid  out  1  redirect request to fetch
- redir_pc  out  32  redirect target
- redir_ready  in  1  fetch accepts redirect

## Operation
- Commit handshake: a commit is accepted at edge T when c_valid & c_ready. No exception, no ERET and no interrupt at T means no action; c_ready stays 1.
- Priority, highest first: interrupt (cp0_has_int), then c_exc bit 0 through bit 10.
- Any exception beats ERET on the same instruction.
- ExcCode values:
  - Int 0; Mod 1.
  - TLBL 2 (if_tlbl, mem_tlbl); TLBS 3.
  - AdEL 4 (if_adel, mem_adel); AdES 5.
  - Sys 8; Bp 9; RI 10; Ov 12.
- EPC and BD:
  - When cp0_status_exl=0: w_cp0_bd=c_bd, and w_cp0_epc = c_bd ? c_pc-4 : c_pc (32-bit wrap).
  - When cp0_status_exl=1: w_cp0_bd=cp0_cause_bd and w_cp0_epc=cp0_epc, leaving both unchanged.
- BadVAddr:
  - if_adel and if_tlbl write c_pc.
  - mem_adel, mem_ades, mem_tlbl, mem_tlbs and mem_mod write c_data_vaddr.
  - All other causes leave badvaddr_ena=0.
- EntryHi: entryhi_ena=1 with the same address for the TLB causes (if_tlbl, mem_tlbl, mem_tlbs, mem_mod).
- Vector: REFILL_VECTOR when the winner is a TLBL/TLBS, c_tlb_refill=1 and cp0_status_exl=0. GEN_VECTOR otherwise.
- ERET: cp0_cls_exl pulses, and redir_pc = cp0_epc sampled at T.
- A faulting or interrupted instruction is not committed. The interrupt takes the PC of the instruction at commit.
- FSM:
  - IDLE: accepts commits. An exception or ERET goes to FLUSH and loads the flush counter with FLUSH_CYCLES-1.
  - FLUSH: flush=1, counter decrements; at 0 goes to REDIR.
  - REDIR: redir_valid=1, redir_pc held stable; on redir_ready goes to IDLE.

## Timing
- Reset values: state IDLE, c_ready=1, and every other output 0, including redir_pc.
- Update strobe: update_ena or cls_exl is high in cycle T+1 only. All w_cp0_* fields are registered from T and valid only in T+1.
- flush is high in cycles T+1 through T+FLUSH_CYCLES.
- redir_valid is high from T+FLUSH_CYCLES+1 until the redir_ready cycle inclusive.
- c_ready is 0 from T+1 until the handshake cycle, and 1 the cycle after it.
- Commit inputs are ignored while not IDLE.
- cp0_* inputs are sampled only at acceptance.
- rst mid-operation: return to IDLE next edge; drop flush, redir_valid and all strobes; the pending redirect is lost.

## Structure
- Shared package exc_pkg holds:
  - ExcCode localparams.
  - c_exc bit indices.
  - FSM state encoding (IDLE, FLUSH, REDIR).
- One combinational sub-module, exc_prio_enc: takes interrupt and c_exc, returns exccode, the badvaddr/entryhi enables and the address source.
- exc_ctrl holds the registers, the counter and the FSM.

## Test plan
- Ov with c_pc=0x80001000, c_bd=0, EXL=0. Expect at T+1: update_ena=1, exccode=12, epc=0x80001000, badvaddr_ena=0. Expect flush for 2 cycles, then redir_pc=0xBFC00380.
- if_adel plus mem_ades together, c_bd=1, c_pc=0x80000004. Expect exccode=4, epc=0x80000000, bd=1, badvaddr=0x80000004.
- mem_tlbs with refill=1, vaddr=0x00402ABC, EXL=0. Expect exccode=3, entryhi=0x00402ABC, redir_pc=0xBFC00200. Repeat with EXL=1: expect 0xBFC00380, and epc/bd equal to the cp0 inputs.
- ERET with cp0_epc=0x80002000. Expect cls_exl for 1 cycle, no update_ena, redir_pc=0x80002000. Hold redir_ready=0 for 3 cycles and check redir_valid and redir_pc stay stable with c_ready=0.
- cp0_has_int together with sys. Expect exccode=0. Assert rst during FLUSH: expect the next cycle to show IDLE, flush=0, redir_valid=0, c_ready=1.
